// File: rtl/branch_target_predictor.sv
// branch_target_predictor: direct-mapped BTB with saturating counters; ports: clk/reset, flush_all, lookup_* request, upd_* resolved branch, busy sweep flag, pred_* registered prediction
module branch_target_predictor #(
  parameter int PC_W      = 48,
  parameter int ENTRIES   = 256,
  parameter int TAG_W     = 8,
  parameter int CTR_W     = 2,
  parameter int INST_LOG2 = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush_all,
  input  logic            lookup_valid,
  input  logic [PC_W-1:0] lookup_pc,
  input  logic            lookup_stall,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target,
  output logic            busy,
  output logic            pred_valid,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [PC_W-1:0] INC = PC_W'(1) << INST_LOG2;
  localparam logic [CTR_W-1:0] CTR_INIT = {1'b1, {(CTR_W-1){1'b0}}};
  typedef enum logic {CLEAR, READY} state_e;
  state_e state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q [ENTRIES];
  logic [PC_W-1:0] tgt_q [ENTRIES];
  logic [CTR_W-1:0] ctr_q [ENTRIES];
  logic pred_valid_q, pred_valid_d, pred_hit_q, pred_hit_d, pred_taken_q, pred_taken_d;
  logic [PC_W-1:0] pred_target_q, pred_target_d;
  logic [IDX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic l_hit, l_taken, u_hit, u_en, wr_en;
  logic [CTR_W-1:0] u_ctr, wr_ctr;
  logic unused_upd_pc;
  assign unused_upd_pc = ^upd_pc;
  assign busy = state_q == CLEAR;
  assign {pred_valid, pred_hit, pred_taken, pred_target} = {pred_valid_q, pred_hit_q, pred_taken_q, pred_target_q};
  always_comb begin
    state_d = flush_all ? CLEAR : (state_q == CLEAR && ptr_q == IDX_W'(ENTRIES-1)) ? READY : state_q;
    ptr_d = flush_all ? '0 : (state_q == CLEAR) ? ptr_q + 1'b1 : ptr_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      ptr_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
    end
  end
  always_comb begin
    l_idx = lookup_pc[INST_LOG2 +: IDX_W];
    l_tag = lookup_pc[INST_LOG2+IDX_W +: TAG_W];
    l_hit = !busy && valid_q[l_idx] && tag_q[l_idx] == l_tag;
    l_taken = l_hit && ctr_q[l_idx][CTR_W-1];
    pred_valid_d = lookup_stall ? pred_valid_q : lookup_valid && !busy;
    pred_hit_d = lookup_stall ? pred_hit_q : l_hit;
    pred_taken_d = lookup_stall ? pred_taken_q : l_taken;
    pred_target_d = lookup_stall ? pred_target_q : l_taken ? tgt_q[l_idx] : lookup_pc + INC;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pred_valid_q <= 1'b0;
      pred_hit_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_target_q <= '0;
    end else begin
      pred_valid_q <= pred_valid_d;
      pred_hit_q <= pred_hit_d;
      pred_taken_q <= pred_taken_d;
      pred_target_q <= pred_target_d;
    end
  end
  always_comb begin
    u_idx = upd_pc[INST_LOG2 +: IDX_W];
    u_tag = upd_pc[INST_LOG2+IDX_W +: TAG_W];
    u_hit = valid_q[u_idx] && tag_q[u_idx] == u_tag;
    u_en = upd_valid && state_q == READY && !flush_all && !reset;
    u_ctr = ctr_q[u_idx];
    wr_en = u_en && (u_hit || upd_taken);
    wr_ctr = !u_hit ? CTR_INIT : upd_taken ? ((&u_ctr) ? u_ctr : u_ctr + 1'b1) : ((u_ctr == '0) ? u_ctr : u_ctr - 1'b1);
  end
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      valid_q[ptr_q] <= 1'b0;
    end else if (wr_en) begin
      valid_q[u_idx] <= 1'b1;
      tag_q[u_idx] <= u_tag;
      ctr_q[u_idx] <= wr_ctr;
      if (upd_taken) tgt_q[u_idx] <= upd_target;
    end
  end
endmodule

// File: doc/branch_target_predictor.md
BRANCH_TARGET_PREDICTOR -- requirements
Module: branch_target_predictor

Interface
REQ-001 SHALL have parameter PC_W, default 48, PC width in bits.
REQ-002 SHALL have parameter ENTRIES, default 256, table depth; power of two, >= 4; IDX_W = log2(ENTRIES).
REQ-003 SHALL have parameter TAG_W, default 8, stored tag bits.
REQ-004 SHALL have parameter CTR_W, default 2, counter width; legal range 2..4.
REQ-005 SHALL have parameter INST_LOG2, default 2, log2 of instruction size in bytes; INST_LOG2+IDX_W+TAG_W <= PC_W.
REQ-006 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port flush_all  input  1  request to invalidate the whole table.
REQ-009 SHALL have port lookup_valid  input  1  fetch-stage lookup request.
REQ-010 SHALL have port lookup_pc  input  PC_W  PC to predict.
REQ-011 SHALL have port lookup_stall  input  1  hold current prediction outputs.
REQ-012 SHALL have port upd_valid  input  1  resolved-branch update strobe.
REQ-013 SHALL have port upd_pc  input  PC_W  PC of the resolved branch.
REQ-014 SHALL have port upd_taken  input  1  actual direction.
REQ-015 SHALL have port upd_target  input  PC_W  actual taken target.
REQ-016 SHALL have port busy  output  1  table sweep in progress.
REQ-017 SHALL have ports pred_valid/pred_hit/pred_taken  output  1 each  response valid, tag hit, predicted taken.
REQ-018 SHALL have port pred_target  output  PC_W  predicted next PC.

Function
REQ-019 SHALL derive index = pc[INST_LOG2+IDX_W-1:INST_LOG2] and tag = pc[INST_LOG2+IDX_W+TAG_W-1:INST_LOG2+IDX_W].
REQ-020 SHALL store per entry: valid bit, tag, PC_W-bit target, CTR_W-bit saturating counter.
REQ-021 SHALL implement FSM states CLEAR and READY; reset enters CLEAR with sweep pointer 0.
REQ-022 SHALL in CLEAR write entry[ptr].valid=0 each cycle, increment ptr, and enter READY after entry ENTRIES-1 is cleared (ENTRIES cycles total).
REQ-023 SHALL assert busy=1 exactly while in CLEAR.
REQ-024 SHALL on flush_all in READY enter CLEAR at ptr 0; flush_all in CLEAR restarts ptr at 0.
REQ-025 SHALL register lookup results with 1-cycle latency: request in cycle N produces outputs in cycle N+1.
REQ-026 SHALL set pred_valid = lookup_valid & !busy of the sampled cycle.
REQ-027 SHALL set pred_hit = 1 when the indexed entry is valid and its tag matches.
REQ-028 SHALL on hit set pred_taken = counter MSB; pred_target = stored target if taken, else lookup_pc + 2^INST_LOG2 (mod 2^PC_W).
REQ-029 SHALL on miss or busy set pred_hit=0, pred_taken=0, pred_target = lookup_pc + 2^INST_LOG2 (mod 2^PC_W).
REQ-030 SHALL, while lookup_stall=1, hold all pred_* outputs unchanged and ignore the lookup inputs.
REQ-031 SHALL on upd_valid in READY with hit: increment counter if taken, decrement if not, saturating at 0 and 2^CTR_W-1; if taken, overwrite target.
REQ-032 SHALL on upd_valid in READY with miss and upd_taken=1 allocate the entry: valid=1, tag, target, counter = 2^(CTR_W-1) (weakly taken).
REQ-033 SHALL on miss with upd_taken=0 leave the table unchanged.
REQ-034 SHALL drop upd_valid while busy=1 and on the cycle flush_all is sampled.
REQ-035 SHALL give a same-cycle lookup and update to the same index the pre-update contents (read-old).

Reset
REQ-036 SHALL on reset drive busy=1, pred_valid=0, pred_hit=0, pred_taken=0, and pred_target=0 on the following cycle.
REQ-037 SHALL restart the sweep from ptr 0 if reset is asserted mid-sweep.

Verification
REQ-038 SHALL check reset: release reset -> busy=1 for 256 cycles, then 0; lookup during busy -> pred_valid=0.
REQ-039 SHALL check allocation: update pc=0x1000, taken, target=0x2000 -> next lookup 0x1000 gives hit=1, taken=1, target=0x2000.
REQ-040 SHALL check saturation: 3 not-taken updates on 0x1000 -> counter 0, taken=0, target=0x1004; 5 taken updates -> counter 3, not 4.
REQ-041 SHALL check aliasing: allocate 0x1000, then lookup 0x1000+(256<<2) -> same index, different tag, so hit=0 and target=0x1404.
REQ-042 SHALL check stall and read-old: hold lookup_stall=1 for 3 cycles -> outputs unchanged; lookup and allocate 0x3000 in the same cycle -> hit=0, then hit=1 on the next lookup.
REQ-043 SHALL check flush: flush_all mid-sweep at ptr 100 -> sweep restarts, busy for 256 more cycles; afterwards all lookups miss; wrap-around lookup_pc=0xFFFFFFFFFFFC -> target=0.
